wb_arbiter: RTL and testbench

- Writeback arbiter sitting directly upstream of the 2-write-port register file.
- Collects completed results from three producers: ALU pipe, load/store unit (LSU) and multiply/divide unit (MDU).
- Each producer uses a valid/ready handshake; the block grants up to two writes per cycle.
- Drives the regfile write ports (we3/wa3/wd3, we4/wa4/wd4) from registered outputs, guaranteeing no same-address dual write and no x0 write.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_starve_ctr.sv | 30 +++
 rtl/wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: source ids and request bundle.
// Request data lanes are WB_XLEN wide; the arbiter's XLEN must not exceed it.
package wb_pkg;

   localparam int WB_XLEN = 32;
   localparam int NUM_SRC = 3;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      SRC_ALU,
      SRC_LSU,
      SRC_MDU
   } src_e;

   typedef struct packed {
      logic               valid;
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating starvation counter; urgent once a source has been denied
// LIMIT consecutive cycles.
module wb_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic denied,
   input  logic clear,
   output logic urgent
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (denied && cnt != MAX) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign urgent = (cnt == MAX);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU/MDU results onto two registered
// regfile write ports with urgency, fixed ALU priority and LSU/MDU round-robin.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   output logic            we3,
   output logic [4:0]      wa3,
   output logic [XLEN-1:0] wd3,
   output logic            we4,
   output logic [4:0]      wa4,
   output logic [XLEN-1:0] wd4
);

   wb_req_t              req [NUM_SRC];
   logic [NUM_SRC-1:0]   cand;
   logic [NUM_SRC-1:0]   grant;
   src_e                 order [NUM_SRC];
   src_e                 p3_src;
   src_e                 p4_src;
   logic                 p3_hit;
   logic                 p4_hit;
   logic                 lsu_urgent;
   logic                 mdu_urgent;
   logic                 lsu_denied;
   logic                 mdu_denied;
   logic                 rr_mdu_first;

   always_comb begin
      req[SRC_ALU] = '{valid: alu_valid, rd: alu_rd,
                       data: WB_XLEN'(alu_data)};
      req[SRC_LSU] = '{valid: lsu_valid, rd: lsu_rd,
                       data: WB_XLEN'(lsu_data)};
      req[SRC_MDU] = '{valid: mdu_valid, rd: mdu_rd,
                       data: WB_XLEN'(mdu_data)};
      for (int i = 0; i < NUM_SRC; i++) begin
         cand[i] = reset_n && req[i].valid && (req[i].rd != REG_X0);
      end
   end

   always_comb begin
      order[0] = SRC_ALU;
      order[1] = SRC_LSU;
      order[2] = SRC_MDU;
      unique case (1'b1)
         lsu_urgent && mdu_urgent: begin
            order[0] = SRC_LSU;
            order[1] = SRC_MDU;
            order[2] = SRC_ALU;
         end
         lsu_urgent && !mdu_urgent: begin
            order[0] = SRC_LSU;
            order[1] = SRC_ALU;
            order[2] = SRC_MDU;
         end
         !lsu_urgent && mdu_urgent: begin
            order[0] = SRC_MDU;
            order[1] = SRC_ALU;
            order[2] = SRC_LSU;
         end
         !lsu_urgent && !mdu_urgent && !rr_mdu_first: begin
            order[0] = SRC_ALU;
            order[1] = SRC_LSU;
            order[2] = SRC_MDU;
         end
         !lsu_urgent && !mdu_urgent && rr_mdu_first: begin
            order[0] = SRC_ALU;
            order[1] = SRC_MDU;
            order[2] = SRC_LSU;
         end
      endcase
   end

   // Second grant must not target the same register as the first.
   always_comb begin
      grant  = '0;
      p3_src = SRC_ALU;
      p4_src = SRC_ALU;
      p3_hit = 1'b0;
      p4_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cand[order[i]] && !p4_hit) begin
            if (!p3_hit) begin
               grant[order[i]] = 1'b1;
               p3_hit          = 1'b1;
               p3_src          = order[i];
            end else if (req[order[i]].rd != req[p3_src].rd) begin
               grant[order[i]] = 1'b1;
               p4_hit          = 1'b1;
               p4_src          = order[i];
            end
         end
      end
   end

   assign alu_ready = reset_n && alu_valid &&
                      ((alu_rd == REG_X0) || grant[SRC_ALU]);
   assign lsu_ready = reset_n && lsu_valid &&
                      ((lsu_rd == REG_X0) || grant[SRC_LSU]);
   assign mdu_ready = reset_n && mdu_valid &&
                      ((mdu_rd == REG_X0) || grant[SRC_MDU]);

   assign lsu_denied = cand[SRC_LSU] && !grant[SRC_LSU];
   assign mdu_denied = cand[SRC_MDU] && !grant[SRC_MDU];

   wb_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_lsu_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .denied  (lsu_denied),
      .clear   (!cand[SRC_LSU] || grant[SRC_LSU]),
      .urgent  (lsu_urgent)
   );

   wb_starve_ctr #(
      .LIMIT (STARVE_LIMIT),
      .CNT_W (CNT_W)
   ) u_mdu_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .denied  (mdu_denied),
      .clear   (!cand[SRC_MDU] || grant[SRC_MDU]),
      .urgent  (mdu_urgent)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_mdu_first <= 1'b0;
      end else if (grant[SRC_LSU] && mdu_denied) begin
         rr_mdu_first <= 1'b1;
      end else if (grant[SRC_MDU] && lsu_denied) begin
         rr_mdu_first <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we3 <= 1'b0;
         wa3 <= '0;
         wd3 <= '0;
         we4 <= 1'b0;
         wa4 <= '0;
         wd4 <= '0;
      end else begin
         we3 <= p3_hit;
         we4 <= p4_hit;
         if (p3_hit) begin
            wa3 <= req[p3_src].rd;
            wd3 <= XLEN'(req[p3_src].data);
         end
         if (p4_hit) begin
            wa4 <= req[p4_src].rd;
            wd4 <= XLEN'(req[p4_src].data);
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model of the
// grant rules, directed scenarios followed by random traffic.
module tb_wb_arbiter;

   localparam int XLEN = 32;
   localparam int LIM  = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            alu_valid, lsu_valid, mdu_valid;
   logic            alu_ready, lsu_ready, mdu_ready;
   logic [4:0]      alu_rd, lsu_rd, mdu_rd;
   logic [XLEN-1:0] alu_data, lsu_data, mdu_data;
   logic            we3, we4;
   logic [4:0]      wa3, wa4;
   logic [XLEN-1:0] wd3, wd4;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_rd    (mdu_rd),
      .mdu_data  (mdu_data),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .we4       (we4),
      .wa4       (wa4),
      .wd4       (wd4)
   );

   typedef struct {
      logic            we3;
      logic [4:0]      wa3;
      logic [XLEN-1:0] wd3;
      logic            we4;
      logic [4:0]      wa4;
      logic [XLEN-1:0] wd4;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // producer state: 0 = ALU, 1 = LSU, 2 = MDU
   bit              iv   [3];
   logic [4:0]      ird  [3];
   logic [XLEN-1:0] idat [3];
   bit              erdy [3];

   // reference model state
   int              m_cnt [3];
   bit              m_rr;
   logic [4:0]      m_wa  [2];
   logic [XLEN-1:0] m_wd  [2];

   function automatic bit in_q(input int q[$], input int s);
      foreach (q[i]) if (q[i] == s) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply();
      alu_valid = iv[0]; alu_rd = ird[0]; alu_data = idat[0];
      lsu_valid = iv[1]; lsu_rd = ird[1]; lsu_data = idat[1];
      mdu_valid = iv[2]; mdu_rd = ird[2]; mdu_data = idat[2];
   endtask

   task automatic model(input bit rst);
      exp_t e;
      int   order[$];
      int   gr[$];
      bit   cand[3];
      bit   den[3];
      if (rst) begin
         for (int s = 0; s < 3; s++) begin
            erdy[s]  = 1'b0;
            m_cnt[s] = 0;
         end
         m_rr = 1'b0;
         m_wa[0] = '0; m_wa[1] = '0;
         m_wd[0] = '0; m_wd[1] = '0;
      end else begin
         for (int s = 0; s < 3; s++) begin
            cand[s] = iv[s] && (ird[s] != 5'd0);
            erdy[s] = iv[s] && (ird[s] == 5'd0);
         end
         if (m_cnt[1] == LIM) order.push_back(1);
         if (m_cnt[2] == LIM) order.push_back(2);
         order.push_back(0);
         if (m_rr) begin
            if (m_cnt[2] != LIM) order.push_back(2);
            if (m_cnt[1] != LIM) order.push_back(1);
         end else begin
            if (m_cnt[1] != LIM) order.push_back(1);
            if (m_cnt[2] != LIM) order.push_back(2);
         end
         foreach (order[i]) begin
            int s = order[i];
            if (cand[s] && gr.size() < 2) begin
               if (gr.size() == 0 || ird[gr[0]] != ird[s]) gr.push_back(s);
            end
         end
         foreach (gr[i]) begin
            erdy[gr[i]] = 1'b1;
            m_wa[i] = ird[gr[i]];
            m_wd[i] = idat[gr[i]];
         end
         for (int s = 0; s < 3; s++) den[s] = cand[s] && !in_q(gr, s);
         if (in_q(gr, 1) && den[2]) m_rr = 1'b1;
         else if (in_q(gr, 2) && den[1]) m_rr = 1'b0;
         for (int s = 1; s < 3; s++)
            m_cnt[s] = den[s] ? ((m_cnt[s] < LIM) ? m_cnt[s] + 1 : LIM) : 0;
      end
      e.we3 = !rst && gr.size() > 0;
      e.we4 = !rst && gr.size() > 1;
      e.wa3 = m_wa[0]; e.wd3 = m_wd[0];
      e.wa4 = m_wa[1]; e.wd4 = m_wd[1];
      sbq.push_back(e);
   endtask

   task automatic cycle(input bit rst);
      logic [2:0] got, want;
      @(negedge clk);
      reset_n = !rst;
      apply();
      #1;
      model(rst);
      got  = {alu_ready, lsu_ready, mdu_ready};
      want = {erdy[0], erdy[1], erdy[2]};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL ready t=%0t got=%b want=%b", $time, got, want);
      end
   endtask

   task automatic set(input int s, input bit v, input logic [4:0] rd,
                      input logic [XLEN-1:0] d);
      iv[s] = v; ird[s] = rd; idat[s] = d;
   endtask

   task automatic idle();
      for (int s = 0; s < 3; s++) set(s, 1'b0, 5'd0, '0);
   endtask

   always @(posedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         #1;
         checks++;
         if (we3 !== e.we3 || wa3 !== e.wa3 || wd3 !== e.wd3 ||
             we4 !== e.we4 || wa4 !== e.wa4 || wd4 !== e.wd4) begin
            errors++;
            $display("FAIL wport t=%0t got p3=%b/%0d/%h p4=%b/%0d/%h want p3=%b/%0d/%h p4=%b/%0d/%h",
                     $time, we3, wa3, wd3, we4, wa4, wd4,
                     e.we3, e.wa3, e.wd3, e.we4, e.wa4, e.wd4);
         end
         checks++;
         if ((we3 && we4 && wa3 == wa4) || (we3 && wa3 == 5'd0) ||
             (we4 && wa4 == 5'd0)) begin
            errors++;
            $display("FAIL guard t=%0t got we3=%b wa3=%0d we4=%b wa4=%0d want distinct nonzero",
                     $time, we3, wa3, we4, wa4);
         end
      end
   end

   initial begin
      bit mdu_done;
      idle();
      apply();

      // reset with all producers asserting
      set(0, 1, 5'd1, 32'h1);
      set(1, 1, 5'd2, 32'h2);
      set(2, 1, 5'd3, 32'h3);
      repeat (3) cycle(1);
      cycle(0);
      idle();
      cycle(0);

      // dual grant
      cycle(1);
      set(0, 1, 5'd3, 32'h11);
      set(1, 1, 5'd4, 32'h22);
      cycle(0);
      idle();
      cycle(0);

      // three requesters, MDU waits one cycle
      cycle(1);
      set(0, 1, 5'd1, 32'hA1);
      set(1, 1, 5'd2, 32'hA2);
      set(2, 1, 5'd3, 32'hA3);
      cycle(0);
      set(0, 0, 5'd0, '0);
      set(1, 0, 5'd0, '0);
      cycle(0);
      idle();
      cycle(0);

      // same destination collision
      cycle(1);
      set(0, 1, 5'd7, 32'hAA);
      set(1, 1, 5'd7, 32'hBB);
      cycle(0);
      set(0, 0, 5'd0, '0);
      cycle(0);
      idle();
      cycle(0);

      // x0 destination consumed without a write
      cycle(1);
      set(2, 1, 5'd0, 32'hDEAD);
      set(0, 1, 5'd5, 32'h55);
      set(1, 1, 5'd6, 32'h66);
      cycle(0);
      idle();
      cycle(0);

      // starvation: MDU becomes urgent after LIM denials
      cycle(1);
      mdu_done = 1'b0;
      for (int i = 0; i < LIM + 2; i++) begin
         set(0, 1, 5'd9, 32'h100 + i);
         set(2, !mdu_done, 5'd9, 32'h99);
         cycle(0);
         if (erdy[2]) mdu_done = 1'b1;
      end
      idle();
      cycle(0);

      // random traffic with occasional reset
      for (int n = 0; n < 600; n++) begin
         for (int s = 0; s < 3; s++) begin
            if (!iv[s] || erdy[s]) begin
               iv[s]   = ($urandom_range(3) != 0);
               ird[s]  = 5'($urandom_range(5));
               idat[s] = $urandom;
            end
         end
         cycle($urandom_range(59) == 0);
      end

      idle();
      cycle(0);
      cycle(0);
      @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d want=0 pending", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
